// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter: the sequencer state
// encoding, the byte width of every requester lane and of the transmitter,
// and the default number of cycles allowed for the transmitter to raise
// tx_busy after a start strobe.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
// Combinational circular-priority picker. Chooses the first set bit of the
// eligible vector at or after the pointer, wrapping at NUM_REQ.
//
// Ports:
//   elig_i   in  NUM_REQ  eligible requesters
//   ptr_i    in  IDW      index with highest priority
//   grant_o  out NUM_REQ  one-hot winner (all zero when nothing eligible)
//   idx_o    out IDW      winner index (0 when nothing eligible)
//   any_o    out 1        at least one requester eligible
// ----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  int           pos;
  logic [IDW-1:0] pos_idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    // Walk the ring starting at the pointer; the wrap is done explicitly so
    // a non-power-of-two NUM_REQ never produces an index >= NUM_REQ.
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_idx = IDW'(pos);
      if (!any_o && elig_i[pos_idx]) begin
        any_o            = 1'b1;
        idx_o            = pos_idx;
        grant_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Grants rotate round-robin between packets; a requester that starts a
// packet keeps the transmitter until it sends a byte flagged last. Each
// byte is sequenced as accept -> one-cycle wr_en -> wait for tx_busy high ->
// wait for tx_busy low. If tx_busy never rises, err_timeout pulses and the
// byte is treated as sent.
//
// Ports:
//   clk_50m       in  1          system clock
//   rst_n         in  1          synchronous active-low reset
//   req_data      in  NUM_REQ*8  byte of requester i at [8i+7:8i]
//   req_valid     in  NUM_REQ    requester i offers a byte
//   req_last      in  NUM_REQ    requester i's byte ends its packet
//   req_ready     out NUM_REQ    one-hot accept strobe (valid&ready)
//   uart_din      out 8          byte to the transmitter
//   uart_wr_en    out 1          transmitter start strobe
//   uart_tx_busy  in  1          transmitter busy
//   grant_id      out IDW        index of the last accepted requester
//   locked        out 1          packet lock held
//   err_timeout   out 1          pulse when tx_busy failed to rise
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                      clk_50m,
  input  logic                      rst_n,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         uart_din,
  output logic                      uart_wr_en,
  input  logic                      uart_tx_busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      locked,
  output logic                      err_timeout
);

  localparam int             CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  // The registered pulse lands in the cycle after the counter reaches
  // BUSY_TIMEOUT-1, i.e. exactly BUSY_TIMEOUT cycles after wr_en.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  state_e             state_q,   state_d;
  logic [IDW-1:0]     ptr_q,     ptr_d;
  logic               lock_q,    lock_d;
  logic [IDW-1:0]     lock_id_q, lock_id_d;
  logic [IDW-1:0]     gid_q,     gid_d;
  logic [BYTE_W-1:0]  din_q,     din_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               err_q,     err_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               accept;
  logic [BYTE_W-1:0]  win_data;
  logic               win_last;

  // While a packet is open only its owner may compete, even if it has
  // momentarily dropped valid; everyone else starves until its last byte.
  always_comb begin
    elig = req_valid;
    if (lock_q) begin
      elig             = '0;
      elig[lock_id_q]  = req_valid[lock_id_q];
    end
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept    = (state_q == IDLE) && !uart_tx_busy && pick_any;
  assign req_ready = accept ? pick_grant : '0;

  // One-hot mux of the winner's lane.
  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_data = req_data[i*BYTE_W +: BYTE_W];
        win_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    gid_d     = gid_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          din_d   = win_data;
          gid_d   = pick_idx;
          state_d = SEND;
          if (win_last) begin
            // Pointer only moves at packet end so packets, not bytes, rotate.
            lock_d = 1'b0;
            ptr_d  = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
          end else begin
            lock_d    = 1'b1;
            lock_id_d = pick_idx;
          end
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (uart_tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!uart_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      gid_q     <= '0;
      din_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      gid_q     <= gid_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign uart_din    = din_q;
  assign uart_wr_en  = (state_q == SEND);
  assign grant_id    = gid_q;
  assign locked      = lock_q;
  assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (8-bit `din`, `wr_en`, `tx_busy`) between NUM_REQ byte-stream requesters, all on `clk_50m`.
- Grants are round-robin.
- Grant is packet-locked: a requester keeps the transmitter from its first byte until it sends a byte with `req_last`=1.
- Sequences each byte as: accept, one-cycle `wr_en`, wait for `tx_busy` to rise, wait for `tx_busy` to fall. A timeout catches a lost start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BUSY_TIMEOUT, 16, cycles allowed after `wr_en` for `tx_busy` to rise
- IDW, $clog2(NUM_REQ), width of the requester index

Ports:
- clk_50m  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req_data  in  NUM_REQ*8  byte from requester i at bits [8i+7:8i]
- req_valid  in  NUM_REQ  requester i has a byte
- req_last  in  NUM_REQ  byte i ends its packet
- req_ready  out  NUM_REQ  byte i accepted this cycle (valid&ready handshake)
- uart_din  out  8  byte to the transmitter
- uart_wr_en  out  1  transmitter start strobe
- uart_tx_busy  in  1  transmitter busy
- grant_id  out  IDW  index of the last accepted requester
- locked  out  1  packet lock held
- err_timeout  out  1  one-cycle pulse when `tx_busy` never rose

Behaviour:
- Reset (rst_n=0 at a clk_50m edge, from any state): state=IDLE.
  - Outputs: req_ready=0, uart_din=0, uart_wr_en=0, grant_id=0, locked=0, err_timeout=0.
  - Internals: rr pointer=0, timeout counter=0.
  - A byte in flight is abandoned; the UART itself is not reset by this block.
- States: IDLE, SEND, WAIT_HI, WAIT_LO (encoding in the package).
- IDLE:
  - Eligible set: if locked, only lock_id's valid bit; otherwise all of req_valid.
  - If the eligible set is non-empty and uart_tx_busy=0, pick the first eligible index at or after the rr pointer (circular).
  - In the same cycle, req_ready[winner]=1 (combinational, one-hot). All other req_ready are 0.
  - Next edge: capture req_data[winner] into uart_din; grant_id=winner; state goes to SEND.
  - Lock update on that edge:
    - req_last[winner]=0: locked=1, lock_id=winner.
    - req_last[winner]=1: locked=0, rr pointer=(winner+1) mod NUM_REQ.
  - If uart_tx_busy=1 or nothing is eligible: stay in IDLE, req_ready=0.
- SEND: uart_wr_en=1 for exactly this cycle, uart_din stable; counter cleared; next state WAIT_HI.
- WAIT_HI:
  - uart_tx_busy=1: go to WAIT_LO.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT-1 without busy: err_timeout pulses for one cycle and the state returns to IDLE. The byte is counted as sent and the lock state is unchanged.
- WAIT_LO: stay while uart_tx_busy=1; on uart_tx_busy=0, go to IDLE.
- Throughput and latency:
  - Latency from valid (IDLE, not busy) to wr_en is 1 cycle.
  - Minimum gap between successive accepts is one full UART frame plus 3 cycles.
- uart_din holds its value between accepts; it changes only on an accept edge.
- While locked, other requesters starve, even if lock_id drops valid. The lock persists indefinitely until lock_id sends a last byte.
- Simultaneous valids are resolved purely by the rr pointer. The pointer moves only on a last=1 accept, so packets rotate fairly.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ, and indices ≥NUM_REQ are never granted.
- req_valid may drop without ready (no stickiness is required of requesters); the arbiter samples afresh each IDLE cycle.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE=0, SEND=1, WAIT_HI=2, WAIT_LO=3)
  - byte width constant 8
  - default BUSY_TIMEOUT
- Sub-module uart_rr_pick: combinational circular-priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Parameterised by NUM_REQ.

Test Plan:
- Single request: req_valid=0001, req_data[0]=0x55, last=1, busy model rises 1 cycle after wr_en and lasts 10 cycles.
  - ready[0] pulses once; uart_wr_en one cycle later with din=0x55.
  - Next accept only after busy falls; locked stays 0; pointer ends at 1.
- Round robin: all four valid, last=1, bytes 0xA0..0xA3 → transmit order 0,1,2,3,0; grant_id follows that order.
- Packet lock: req1 sends 3 bytes (last=0,0,1) while req0, req2, req3 are all valid.
  - Bytes from req1 go out consecutively; locked=1 after bytes 1 and 2, 0 after byte 3.
  - The next grant goes to req2.
- Timeout: tx_busy held 0 after wr_en → err_timeout pulses exactly BUSY_TIMEOUT cycles after the wr_en cycle; the state returns to IDLE and the next request is served.
- Busy at idle: tx_busy=1 while req_valid=0001 → no ready and no wr_en until busy falls; accept follows in the first cycle busy=0.
- Mid-operation reset: rst_n=0 for one edge during WAIT_LO with locked=1 → all outputs at reset values next cycle; locked=0, pointer=0; the first grant after reset goes to req0 if it is valid.
